// File: rtl/button_pkg.sv
// Shared types and default timing constants for the push-button trigger front end.
package button_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS_WAIT,
    S_HELD,
    S_REL_WAIT
  } state_t;

  // The animation's slow clock is the top bit of a 24-bit divider on the fast clock.
  localparam int ANIM_SLOW_BIT   = 23;
  localparam int CLK_HZ          = 50_000_000;

  // One slow-clock period, and seven of them (a full 5-LED fill run).
  localparam int ACTIVE_HOLD_DEF = 1 << (ANIM_SLOW_BIT + 1);
  localparam int LOCKOUT_DEF     = 7 << (ANIM_SLOW_BIT + 1);

  // 10 ms debounce and a 1 s long-press threshold at CLK_HZ.
  localparam int DEBOUNCE_DEF    = CLK_HZ / 100;
  localparam int LONG_DEF        = CLK_HZ;

endpackage

// File: rtl/button_trigger_sync.sv
// Two-flop synchroniser for an asynchronous panel input.
module btn_sync (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic synced
);

  logic meta;

  // Two-stage capture; only the second stage is used by downstream logic.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta   <= 1'b0;
      synced <= 1'b0;
    end else begin
      meta   <= raw;
      synced <= meta;
    end
  end

endmodule

// File: rtl/button_trigger.sv
// Debounced push-button front end: turns each accepted press into a stretched
// `active` level for the slow animation domain, with a lockout window and a
// long-press pulse.
module button_trigger
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES    = DEBOUNCE_DEF,
  parameter int ACTIVE_HOLD_CYCLES = ACTIVE_HOLD_DEF,
  parameter int LOCKOUT_CYCLES     = LOCKOUT_DEF,
  parameter int LONG_CYCLES        = LONG_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic active,
  output logic busy,
  output logic btn_level,
  output logic ignored,
  output logic long_press
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(ACTIVE_HOLD_CYCLES);
  localparam int KW = $clog2(LOCKOUT_CYCLES);
  localparam int GW = $clog2(LONG_CYCLES);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(ACTIVE_HOLD_CYCLES - 1);
  localparam logic [KW-1:0] LOCK_LAST = KW'(LOCKOUT_CYCLES - 1);
  localparam logic [GW-1:0] LONG_LAST = GW'(LONG_CYCLES - 1);

  // `active` must never outlive the lockout, and every counter needs at least one bit.
  if (ACTIVE_HOLD_CYCLES > LOCKOUT_CYCLES || DEBOUNCE_CYCLES < 2 ||
      ACTIVE_HOLD_CYCLES < 2 || LOCKOUT_CYCLES < 2 || LONG_CYCLES < 2) begin : g_param_check
    $error("button_trigger: illegal timing parameters");
  end

  logic          s2;
  state_t        state, state_nxt;
  logic [DW-1:0] deb_cnt;
  logic [HW-1:0] hold_cnt;
  logic [KW-1:0] lock_cnt;
  logic [GW-1:0] long_cnt;
  logic          long_fired;
  logic          deb_clr, deb_inc, press_evt, rel_done, held, held_nxt;

  btn_sync u_sync (
    .clk    (clk),
    .reset  (reset),
    .raw    (btn_raw),
    .synced (s2)
  );

  assign held     = (state == S_HELD) || (state == S_REL_WAIT);
  assign held_nxt = (state_nxt == S_HELD) || (state_nxt == S_REL_WAIT);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Debounce FSM: a level change is accepted only after it has been seen
  // on DEBOUNCE_CYCLES+1 consecutive edges; any reversal restarts the wait.
  always_comb begin
    state_nxt = state;
    deb_clr   = 1'b0;
    deb_inc   = 1'b0;
    press_evt = 1'b0;
    rel_done  = 1'b0;
    case (state)
      S_IDLE: begin
        if (s2) begin
          state_nxt = S_PRESS_WAIT;
          deb_clr   = 1'b1;
        end
      end
      S_PRESS_WAIT: begin
        if (!s2) begin
          state_nxt = S_IDLE;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt = S_HELD;
          press_evt = 1'b1;
        end else begin
          deb_inc = 1'b1;
        end
      end
      S_HELD: begin
        if (!s2) begin
          state_nxt = S_REL_WAIT;
          deb_clr   = 1'b1;
        end
      end
      S_REL_WAIT: begin
        if (s2) begin
          state_nxt = S_HELD;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt = S_IDLE;
          rel_done  = 1'b1;
        end else begin
          deb_inc = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Shared debounce counter and the registered debounced level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_cnt   <= '0;
      btn_level <= 1'b0;
    end else begin
      if (deb_clr)      deb_cnt <= '0;
      else if (deb_inc) deb_cnt <= deb_cnt + 1'b1;
      btn_level <= held_nxt;
    end
  end

  // Long-press timer: runs while the button is debounced-down (release
  // bounces included), fires once, then parks until the release is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      long_cnt   <= '0;
      long_fired <= 1'b0;
      long_press <= 1'b0;
    end else begin
      long_press <= held && (long_cnt == LONG_LAST) && !long_fired;
      if (rel_done) begin
        long_cnt   <= '0;
        long_fired <= 1'b0;
      end else if (held) begin
        if (long_cnt == LONG_LAST) long_fired <= 1'b1;
        else                       long_cnt   <= long_cnt + 1'b1;
      end
    end
  end

  // Trigger stretch and lockout. A press during lockout (including the
  // lockout's final cycle) is reported as ignored and changes nothing else.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active   <= 1'b0;
      busy     <= 1'b0;
      ignored  <= 1'b0;
      hold_cnt <= '0;
      lock_cnt <= '0;
    end else begin
      ignored <= press_evt && busy;
      if (press_evt && !busy) begin
        active   <= 1'b1;
        busy     <= 1'b1;
        hold_cnt <= '0;
        lock_cnt <= '0;
      end else begin
        if (active) begin
          if (hold_cnt == HOLD_LAST) begin
            active   <= 1'b0;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        if (busy) begin
          if (lock_cnt == LOCK_LAST) begin
            busy     <= 1'b0;
            lock_cnt <= '0;
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_button_trigger.sv
// Self-checking bench for button_trigger with shortened timing parameters.
module tb_button_trigger;

  localparam int DEB  = 4;
  localparam int HOLD = 8;
  localparam int LOCK = 20;
  localparam int LONG = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_raw = 1'b0;
  logic active, busy, btn_level, ignored, long_press;

  int n_cmp = 0;
  int n_bad = 0;

  button_trigger #(
    .DEBOUNCE_CYCLES    (DEB),
    .ACTIVE_HOLD_CYCLES (HOLD),
    .LOCKOUT_CYCLES     (LOCK),
    .LONG_CYCLES        (LONG)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .active     (active),
    .busy       (busy),
    .btn_level  (btn_level),
    .ignored    (ignored),
    .long_press (long_press)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: button seen two edges late; the debounced level flips
  // once the opposite value has been seen on DEB+1 consecutive edges. A rising
  // flip is a press; it triggers HOLD cycles of active and LOCK of busy unless
  // busy was already high. long_press fires LONG edges after the press while
  // still debounced-down.
  int edge_n = 0;
  int m_s1, m_s2, run, m_level, act_left, busy_left, m_ign, m_long;
  int press_edge, rise_edge, fall_edge, busy_fall_edge, ign_edge, long_edge;
  int press_cnt, ign_cnt, rise_cnt;

  always @(posedge clk or posedge reset) begin
    int s_in, busy_pre, press;
    if (reset) begin
      m_s1 = 0; m_s2 = 0; run = 0; m_level = 0;
      act_left = 0; busy_left = 0; m_ign = 0; m_long = 0;
      press_edge = -1000;
    end else begin
      edge_n++;
      s_in = m_s2;
      m_s2 = m_s1;
      m_s1 = int'(btn_raw);
      m_ign = 0;
      m_long = 0;
      busy_pre = (busy_left > 0);
      if (m_level == 1 && edge_n - press_edge == LONG) begin
        m_long = 1;
        long_edge = edge_n;
      end
      press = 0;
      if (s_in != m_level) begin
        run++;
        if (run == DEB + 1) begin
          m_level = 1 - m_level;
          run = 0;
          if (m_level == 1) begin
            press = 1;
            press_edge = edge_n;
            press_cnt++;
          end
        end
      end else begin
        run = 0;
      end
      if (press == 1 && busy_pre == 0) begin
        act_left = HOLD;
        busy_left = LOCK;
        rise_edge = edge_n;
        rise_cnt++;
      end else begin
        if (press == 1) begin
          m_ign = 1;
          ign_edge = edge_n;
          ign_cnt++;
        end
        if (act_left > 0) begin
          act_left--;
          if (act_left == 0) fall_edge = edge_n;
        end
        if (busy_left > 0) begin
          busy_left--;
          if (busy_left == 0) busy_fall_edge = edge_n;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      chk("active",     32'(active),     32'(act_left > 0));
      chk("busy",       32'(busy),       32'(busy_left > 0));
      chk("btn_level",  32'(btn_level),  32'(m_level));
      chk("ignored",    32'(ignored),    32'(m_ign));
      chk("long_press", 32'(long_press), 32'(m_long));
    end
  end

  // Drive btn_raw for n consecutive sampling edges (called at a negedge).
  task automatic drive(input logic v, input int n);
    btn_raw = v;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, e1, p0, i0, r0;
    #1;
    chk("reset_active", 32'(active), 0);
    chk("reset_busy",   32'(busy), 0);
    chk("reset_level",  32'(btn_level), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    drive(0, 3);

    // 1: clean press held 40 cycles.
    e0 = edge_n + 1;
    drive(1, 40);
    drive(0, 20);
    chk("t1_rise_edge",      32'(rise_edge - e0), 6);
    chk("t1_fall_edge",      32'(fall_edge - e0), 14);
    chk("t1_busy_fall_edge", 32'(busy_fall_edge - e0), 26);
    chk("t1_long_edge",      32'(long_edge - e0), 22);

    // 2: bounce 1,1,0,1,0 then low.
    p0 = press_cnt; i0 = ign_cnt;
    drive(1, 2); drive(0, 1); drive(1, 1); drive(0, 20);
    chk("t2_presses", 32'(press_cnt - p0), 0);
    chk("t2_ignored", 32'(ign_cnt - i0), 0);

    // 3: second press during lockout is ignored, busy not extended.
    e0 = edge_n + 1; r0 = rise_cnt;
    drive(1, 10); drive(0, 9); drive(1, 10); drive(0, 20);
    chk("t3_ign_edge",       32'(ign_edge - e0), 25);
    chk("t3_busy_fall_edge", 32'(busy_fall_edge - e0), 26);
    chk("t3_rises",          32'(rise_cnt - r0), 1);

    // 4: two-cycle release glitch while held.
    e0 = edge_n + 1; p0 = press_cnt;
    drive(1, 12); drive(0, 2); drive(1, 20); drive(0, 20);
    chk("t4_long_edge", 32'(long_edge - e0), 22);
    chk("t4_presses",   32'(press_cnt - p0), 1);

    // 5: press lands on busy's final cycle, then a press after lockout.
    e0 = edge_n + 1;
    drive(1, 8); drive(0, 12); drive(1, 10); drive(0, 10);
    chk("t5_ign_edge", 32'(ign_edge - e0), 26);
    e1 = edge_n + 1;
    drive(1, 10); drive(0, 20);
    chk("t5_rise_edge", 32'(rise_edge - e1), 6);
    chk("t5_fall_edge", 32'(fall_edge - e1), 14);

    // 6: asynchronous reset while active and busy.
    e0 = edge_n + 1;
    drive(1, 9);
    chk("t6_pre_active", 32'(active), 1);
    chk("t6_pre_busy",   32'(busy), 1);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_active", 32'(active), 0);
    chk("t6_async_busy",   32'(busy), 0);
    chk("t6_async_level",  32'(btn_level), 0);
    @(negedge clk);
    reset = 1'b0;
    e1 = edge_n + 1;
    drive(1, 12);
    chk("t6_rise_edge", 32'(rise_edge - e1), 6);
    drive(0, 30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
